// File: rtl/mips_test_ctrl.sv
// Test/boot controller for the pipelined MIPS32 core: register-file init, program load, run, register dump.
// Optional macro SELF_CHECK_EN adds exp_data/mismatch/err_count dump comparison.
module mips_test_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int NUM_REGS  = 32,
  parameter int RF_AW     = 5,
  parameter int DUMP_REGS = 6,
  parameter int TMO_W     = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [TMO_W-1:0]  timeout,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              core_run,
  input  logic              core_halted,
  output logic              dump_valid,
  output logic [RF_AW-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [TMO_W-1:0]  cycle_count,
`ifdef SELF_CHECK_EN
  input  logic [DATA_W-1:0] exp_data,
  output logic              mismatch,
  output logic [RF_AW:0]    err_count,
`endif
  output logic [2:0]        dbg_state
);

  // Handshakes: a word moves on any rising edge where valid and ready are both high;
  // valid and its payload never change while waiting for ready.

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_RUN, S_RD, S_CAP, S_OUT, S_DONE
  } state_t;

  localparam logic [RF_AW-1:0] LAST_REG  = RF_AW'(NUM_REGS - 1);
  localparam logic [RF_AW-1:0] LAST_DUMP = RF_AW'(DUMP_REGS - 1);

  state_t              state, state_n;
  logic [RF_AW-1:0]    cnt;
  logic [ADDR_W:0]     widx;
  logic [ADDR_W:0]     len_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [DATA_W-1:0]   dump_q;
  logic                accept_start;
  logic                tmo_hit;
  logic                load_last;

  assign dbg_state    = state;
  assign accept_start = start && (state == S_IDLE || state == S_DONE);
  assign tmo_hit      = (tmo_q != '0) &&
                        (({1'b0, cycle_count} + 1'b1) == {1'b0, tmo_q});
  assign load_last    = prog_valid && ((widx + 1'b1) == len_q);

  always_ff @(posedge clk1) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    prog_ready = 1'b0;
    core_run   = 1'b0;
    rf_we      = 1'b0;
    rf_addr    = '0;
    rf_wdata   = '0;
    dump_valid = 1'b0;
    dump_idx   = '0;
    dump_data  = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_INIT;
      end
      S_INIT: begin
        rf_we    = 1'b1;
        rf_addr  = cnt;
        rf_wdata = DATA_W'(cnt);
        if (cnt == LAST_REG) state_n = (len_q == '0) ? S_RUN : S_LOAD;
      end
      S_LOAD: begin
        prog_ready = 1'b1;
        if (load_last) state_n = S_RUN;
      end
      S_RUN: begin
        core_run = 1'b1;
        if (core_halted || tmo_hit) state_n = S_RD;
      end
      S_RD: begin
        rf_addr = cnt;
        state_n = S_CAP;
      end
      S_CAP: begin
        // synchronous-read register file: data for cnt is visible this cycle
        rf_addr = cnt;
        state_n = S_OUT;
      end
      S_OUT: begin
        dump_valid = 1'b1;
        dump_idx   = cnt;
        dump_data  = dump_q;
        if (dump_ready) state_n = (cnt == LAST_DUMP) ? S_DONE : S_RD;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_n = S_INIT;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt         <= '0;
      widx        <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      dump_q      <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cycle_count <= '0;
      timed_out   <= 1'b0;
`ifdef SELF_CHECK_EN
      mismatch    <= 1'b0;
      err_count   <= '0;
`endif
    end else begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      if (accept_start) begin
        len_q       <= prog_len;
        tmo_q       <= timeout;
        cnt         <= '0;
        widx        <= '0;
        cycle_count <= '0;
        timed_out   <= 1'b0;
`ifdef SELF_CHECK_EN
        mismatch    <= 1'b0;
        err_count   <= '0;
`endif
      end
      case (state)
        S_INIT: cnt <= (cnt == LAST_REG) ? '0 : cnt + 1'b1;
        S_LOAD: begin
          if (prog_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= widx[ADDR_W-1:0];
            imem_wdata <= prog_data;
            widx       <= widx + 1'b1;
          end
        end
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          // a halt seen on the same cycle as the limit is a normal finish
          if (!core_halted && tmo_hit) timed_out <= 1'b1;
        end
        S_CAP: dump_q <= rf_rdata;
        S_OUT: begin
          if (dump_ready) begin
            cnt <= (cnt == LAST_DUMP) ? '0 : cnt + 1'b1;
`ifdef SELF_CHECK_EN
            if (dump_q != exp_data) begin
              mismatch <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_test_ctrl.md
Name: mips_test_ctrl

Overview:
- Synthesizable, parametrised test/boot controller for the pipelined MIPS32 core; runs on one clock.
- Sequence: initialise the register file to Reg[k]=k, stream a program into instruction memory, release the core, wait for HALTED or timeout, then stream out a register window.
- Sits between an external host/bench stream and the core's imem write port, register-file debug port and run/halt lines.

Parameters:
- DATA_W, 32, instruction/register data width
- ADDR_W, 10, instruction memory address width (max program 2**ADDR_W words)
- NUM_REGS, 32, register-file entries initialised (k=0..NUM_REGS-1)
- RF_AW, 5, register-file address width; NUM_REGS <= 2**RF_AW
- DUMP_REGS, 6, registers dumped after the run (indices 0..DUMP_REGS-1), 1..NUM_REGS
- TMO_W, 16, width of the cycle counter and timeout value

Ports:
- clk1  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sequence when idle
- prog_len  in  ADDR_W+1  words to load; sampled on accepted start
- timeout  in  TMO_W  run-cycle limit, 0 = no limit; sampled on accepted start
- prog_valid  in  1  program word valid
- prog_data  in  DATA_W  program word
- prog_ready  out  1  controller accepts word (valid&ready = transfer)
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  instruction memory write address
- imem_wdata  out  DATA_W  instruction memory write data
- rf_we  out  1  register-file write enable
- rf_addr  out  RF_AW  register-file write/read address
- rf_wdata  out  DATA_W  register-file write data
- rf_rdata  in  DATA_W  register-file read data, valid 1 cycle after rf_addr
- core_run  out  1  core enable; high only in RUN
- core_halted  in  1  core HALTED flag
- dump_valid  out  1  dump word valid
- dump_idx  out  RF_AW  register index of dump word
- dump_data  out  DATA_W  register value
- dump_ready  in  1  host accepts dump word
- busy  out  1  state != IDLE and != DONE
- done  out  1  sequence finished; held until next accepted start
- timed_out  out  1  run ended by timeout; held with done
- cycle_count  out  TMO_W  core_run cycles of last run, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. rst mid-sequence aborts immediately, including core_run dropping the next edge; no partial dump.
- IDLE/DONE + start=1: latch prog_len and timeout, clear done, timed_out and cycle_count, go INIT.
- start while busy is ignored.
- INIT: rf_we=1, rf_addr=k, rf_wdata=k zero-extended, k=0..NUM_REGS-1, one write per cycle (NUM_REGS cycles). Then LOAD, or RUN if prog_len==0.
- LOAD: prog_ready=1. Each transfer produces imem_we=1, imem_addr=word index (from 0), imem_wdata=prog_data registered (1-cycle latency). No transfer leaves outputs idle and the index held. After the prog_len-th transfer, prog_ready drops the same edge; go RUN.
- RUN: core_run=1; cycle_count increments each RUN cycle, saturating at all-ones.
  - core_halted sampled high: go DUMP.
  - timeout!=0 and cycle_count+1==timeout: set timed_out, go DUMP.
  - Both on the same cycle: halt wins, timed_out=0.
  - core_halted already high on RUN entry: exactly 1 RUN cycle.
- DUMP, per index i=0..DUMP_REGS-1:
  - issue rf_addr=i for 1 cycle (RD).
  - capture rf_rdata next cycle and assert dump_valid with dump_idx=i (OUT).
  - dump_valid, dump_idx and dump_data stay stable until dump_ready; transfer on valid&ready.
  - After the last transfer go DONE.
- DONE: done=1, busy=0, core_run=0; outputs otherwise idle.
- Width rule: rf_wdata = k zero-extended to DATA_W. Address counters wrap only at 2**width, which valid parameters never reach.

Optional Feature:
- Macro SELF_CHECK_EN.
- Enabled: adds input exp_data (DATA_W), outputs mismatch (1) and err_count (RF_AW+1).
  - On each dump transfer, dump_data != exp_data sets mismatch and increments err_count, saturating.
  - Both are cleared on accepted start and on rst.
- Disabled: these ports and their logic do not exist; dump behaviour is identical.

Test Plan:
- Reset then idle: outputs all 0; start with prog_len=9, timeout=0 -> 32 rf writes, Reg[k]=k, then prog_ready high.
- Program the 9-word ADDI/OR/ADD/ADD/HLT sequence (2801000a..fc000000) into the real core -> dump R0..R5 = 0,10,20,25,30,55; done=1, timed_out=0.
- Stub core never halts, timeout=50 -> cycle_count=50, timed_out=1, dump occurs, done=1.
- prog_len=0, core_halted tied high -> no imem_we, 1 RUN cycle, cycle_count=1.
- prog_valid toggled 1-0-1 and dump_ready held low 5 cycles -> imem addresses contiguous; dump_data/dump_idx stable while stalled.
- rst asserted during LOAD word 4 -> next cycle all outputs 0; new start reruns from INIT. With SELF_CHECK_EN, exp R4=31 -> mismatch=1, err_count=1.
